axil_slave_regfile: RTL and testbench

- AXI4-Lite responder: a flop-based register file that answers the AXI4-Lite master on the same interconnect.
- Independent write and read channel FSMs.
- Addresses are word indices with no byte offset; the master issues AWADDR/ARADDR = 0..7.
- Out-of-range or rejected accesses get SLVERR.

---
 rtl/axil_slave_regfile_if.sv | 46 ++++
 rtl/axil_slave_regfile.sv | 240 ++++++++++++++++++++++++
 tb/tb_axil_slave_regfile.sv | 379 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_slave_regfile_if.sv
// AXI4-Lite bus bundle between one master and the register-file responder.
// Latency: none, plain signal bundle.
// Backpressure: carries VALID/READY on all five channels; no buffering here.
// Ports: AW (AWADDR, AWPROT, AWVALID, AWREADY), W (WDATA, WSTRB, WVALID, WREADY),
//        B (BRESP, BVALID, BREADY), AR (ARADDR, ARPROT, ARVALID, ARREADY),
//        R (RDATA, RRESP, RVALID, RREADY). Modports: master, slave.
interface axil_slave_regfile_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic [2:0]              AWPROT;
  logic                    AWVALID;
  logic                    AWREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WVALID;
  logic                    WREADY;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic [2:0]              ARPROT;
  logic                    ARVALID;
  logic                    ARREADY;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RVALID;
  logic                    RREADY;

  modport slave (
    input  AWADDR, AWPROT, AWVALID, output AWREADY,
    input  WDATA, WSTRB, WVALID,    output WREADY,
    output BRESP, BVALID,           input  BREADY,
    input  ARADDR, ARPROT, ARVALID, output ARREADY,
    output RDATA, RRESP, RVALID,    input  RREADY
  );

  modport master (
    output AWADDR, AWPROT, AWVALID, input  AWREADY,
    output WDATA, WSTRB, WVALID,    input  WREADY,
    input  BRESP, BVALID,           output BREADY,
    output ARADDR, ARPROT, ARVALID, input  ARREADY,
    input  RDATA, RRESP, RVALID,    output RREADY
  );
endinterface

// File: rtl/axil_slave_regfile.sv
// AXI4-Lite responder backed by a flop register file of DEPTH words (word-index addressing).
// Latency: BVALID one cycle after the last AW/W handshake; RVALID one cycle after the AR handshake.
// Backpressure: one outstanding write and one outstanding read; readies stay low until BREADY/RREADY.
// Ports: ACLK (clock), reset (async, active-high), s_axil (axil_slave_regfile_if.slave).
// Optional macro AXIL_SLAVE_PROT_CHECK_EN: reject accesses with PROT[2]=1 (instruction) with SLVERR.
module axil_slave_regfile #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                   ACLK,
  input  logic                   reset,
  axil_slave_regfile_if.slave    s_axil
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH == 2**ADDR_WIDTH still compares correctly.
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(DEPTH);

`ifdef AXIL_SLAVE_PROT_CHECK_EN
  localparam bit PROT_CHECK = 1'b1;
`else
  localparam bit PROT_CHECK = 1'b0;
`endif

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {W_RST, W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_RST, R_IDLE, R_DATA} rstate_t;

  // ---------------------------------------------------------------- state
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  wstate_t               r_wstate, w_wstate_nxt;
  logic                  r_awready, w_awready_nxt;
  logic                  r_wready, w_wready_nxt;
  logic                  r_bvalid, w_bvalid_nxt;
  logic [1:0]            r_bresp, w_bresp_nxt;
  // Half of a split write held until the other channel arrives.
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic                  r_awinstr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]     r_wstrb;

  rstate_t               r_rstate, w_rstate_nxt;
  logic                  r_arready, w_arready_nxt;
  logic                  r_rvalid, w_rvalid_nxt;
  logic [1:0]            r_rresp, w_rresp_nxt;
  logic [DATA_WIDTH-1:0] r_rdata, w_rdata_nxt;

  // ---------------------------------------------------------------- write path
  logic                  w_aw_hs, w_w_hs;
  logic                  w_cap_a, w_cap_d, w_commit;
  logic [ADDR_WIDTH-1:0] w_cm_addr;
  logic                  w_cm_instr;
  logic [DATA_WIDTH-1:0] w_cm_data;
  logic [STRB_W-1:0]     w_cm_strb;
  logic [IDX_W-1:0]      w_cm_idx;
  logic                  w_werr;

  assign w_aw_hs = s_axil.AWVALID & r_awready;
  assign w_w_hs  = s_axil.WVALID  & r_wready;

  // Commit operands: live bus values, except the half already captured.
  always_comb begin
    w_cm_addr  = s_axil.AWADDR;
    w_cm_instr = s_axil.AWPROT[2];
    w_cm_data  = s_axil.WDATA;
    w_cm_strb  = s_axil.WSTRB;
    if (r_wstate == W_HAVE_A) begin
      w_cm_addr  = r_awaddr;
      w_cm_instr = r_awinstr;
    end
    if (r_wstate == W_HAVE_D) begin
      w_cm_data = r_wdata;
      w_cm_strb = r_wstrb;
    end
  end

  assign w_cm_idx = w_cm_addr[IDX_W-1:0];
  assign w_werr   = ({1'b0, w_cm_addr} >= DEPTH_LIM) | (PROT_CHECK & w_cm_instr);

  always_comb begin
    w_wstate_nxt  = r_wstate;
    w_awready_nxt = r_awready;
    w_wready_nxt  = r_wready;
    w_bvalid_nxt  = r_bvalid;
    w_bresp_nxt   = r_bresp;
    w_cap_a       = 1'b0;
    w_cap_d       = 1'b0;
    w_commit      = 1'b0;
    case (r_wstate)
      W_RST: begin
        w_wstate_nxt  = W_IDLE;
        w_awready_nxt = 1'b1;
        w_wready_nxt  = 1'b1;
      end
      W_IDLE: begin
        if (w_aw_hs && w_w_hs) begin
          w_commit = 1'b1;
        end else if (w_aw_hs) begin
          w_cap_a       = 1'b1;
          w_awready_nxt = 1'b0;
          w_wstate_nxt  = W_HAVE_A;
        end else if (w_w_hs) begin
          w_cap_d      = 1'b1;
          w_wready_nxt = 1'b0;
          w_wstate_nxt = W_HAVE_D;
        end
      end
      W_HAVE_A: if (w_w_hs)  w_commit = 1'b1;
      W_HAVE_D: if (w_aw_hs) w_commit = 1'b1;
      W_RESP: begin
        if (s_axil.BREADY) begin
          w_bvalid_nxt  = 1'b0;
          w_awready_nxt = 1'b1;
          w_wready_nxt  = 1'b1;
          w_wstate_nxt  = W_IDLE;
        end
      end
      default: w_wstate_nxt = W_RST;
    endcase
    if (w_commit) begin
      w_awready_nxt = 1'b0;
      w_wready_nxt  = 1'b0;
      w_bvalid_nxt  = 1'b1;
      w_bresp_nxt   = w_werr ? RESP_SLVERR : RESP_OKAY;
      w_wstate_nxt  = W_RESP;
    end
  end

  always_ff @(posedge ACLK or posedge reset) begin
    if (reset) begin
      r_wstate  <= W_RST;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= 2'b00;
      r_awaddr  <= '0;
      r_awinstr <= 1'b0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else begin
      r_wstate  <= w_wstate_nxt;
      r_awready <= w_awready_nxt;
      r_wready  <= w_wready_nxt;
      r_bvalid  <= w_bvalid_nxt;
      r_bresp   <= w_bresp_nxt;
      if (w_cap_a) begin
        r_awaddr  <= s_axil.AWADDR;
        r_awinstr <= s_axil.AWPROT[2];
      end
      if (w_cap_d) begin
        r_wdata <= s_axil.WDATA;
        r_wstrb <= s_axil.WSTRB;
      end
    end
  end

  // Rejected or out-of-range commits leave memory untouched.
  always_ff @(posedge ACLK or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_commit && !w_werr) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (w_cm_strb[b]) r_mem[w_cm_idx][8*b +: 8] <= w_cm_data[8*b +: 8];
      end
    end
  end

  assign s_axil.AWREADY = r_awready;
  assign s_axil.WREADY  = r_wready;
  assign s_axil.BVALID  = r_bvalid;
  assign s_axil.BRESP   = r_bresp;

  // ---------------------------------------------------------------- read path
  logic             w_ar_hs;
  logic             w_rerr;
  logic [IDX_W-1:0] w_ar_idx;

  assign w_ar_hs  = s_axil.ARVALID & r_arready;
  assign w_ar_idx = s_axil.ARADDR[IDX_W-1:0];
  assign w_rerr   = ({1'b0, s_axil.ARADDR} >= DEPTH_LIM) | (PROT_CHECK & s_axil.ARPROT[2]);

  // The memory read uses pre-edge contents, so a same-edge write is not visible.
  always_comb begin
    w_rstate_nxt  = r_rstate;
    w_arready_nxt = r_arready;
    w_rvalid_nxt  = r_rvalid;
    w_rresp_nxt   = r_rresp;
    w_rdata_nxt   = r_rdata;
    case (r_rstate)
      R_RST: begin
        w_rstate_nxt  = R_IDLE;
        w_arready_nxt = 1'b1;
      end
      R_IDLE: begin
        if (w_ar_hs) begin
          w_rdata_nxt   = w_rerr ? '0 : r_mem[w_ar_idx];
          w_rresp_nxt   = w_rerr ? RESP_SLVERR : RESP_OKAY;
          w_arready_nxt = 1'b0;
          w_rvalid_nxt  = 1'b1;
          w_rstate_nxt  = R_DATA;
        end
      end
      R_DATA: begin
        if (s_axil.RREADY) begin
          w_rvalid_nxt  = 1'b0;
          w_arready_nxt = 1'b1;
          w_rstate_nxt  = R_IDLE;
        end
      end
      default: w_rstate_nxt = R_RST;
    endcase
  end

  always_ff @(posedge ACLK or posedge reset) begin
    if (reset) begin
      r_rstate  <= R_RST;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rresp   <= 2'b00;
      r_rdata   <= '0;
    end else begin
      r_rstate  <= w_rstate_nxt;
      r_arready <= w_arready_nxt;
      r_rvalid  <= w_rvalid_nxt;
      r_rresp   <= w_rresp_nxt;
      r_rdata   <= w_rdata_nxt;
    end
  end

  assign s_axil.ARREADY = r_arready;
  assign s_axil.RVALID  = r_rvalid;
  assign s_axil.RRESP   = r_rresp;
  assign s_axil.RDATA   = r_rdata;

endmodule

// File: tb/tb_axil_slave_regfile.sv
// Bench for axil_slave_regfile: scenario tasks drive AXI4-Lite traffic against a reference model.
// Expected responses are queued when a request is driven and popped when the DUT responds.
// Honours AXIL_SLAVE_PROT_CHECK_EN so the model matches the build under test.
module tb_axil_slave_regfile;

  localparam int MAXW = 40;
`ifdef AXIL_SLAVE_PROT_CHECK_EN
  localparam bit PROT_EN = 1'b1;
`else
  localparam bit PROT_EN = 1'b0;
`endif

  logic ACLK;
  logic reset;
  int   chk_total = 0;
  int   chk_pass  = 0;

  axil_slave_regfile_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

  axil_slave_regfile #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(8)) dut (
    .ACLK  (ACLK),
    .reset (reset),
    .s_axil(bus)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------------------------------------------------------- model + scoreboard
  logic [31:0] model_mem [8];
  logic [1:0]  exp_b  [$];
  logic [31:0] exp_rd [$];
  logic [1:0]  exp_rr [$];

  function automatic logic [1:0] model_write(input logic [7:0] a, input logic [31:0] d,
                                             input logic [3:0] s, input logic [2:0] p);
    if (a >= 8'd8 || (PROT_EN && p[2])) return 2'b10;
    for (int b = 0; b < 4; b++) if (s[b]) model_mem[a[2:0]][8*b +: 8] = d[8*b +: 8];
    return 2'b00;
  endfunction

  function automatic logic [1:0] model_read(input logic [7:0] a, input logic [2:0] p,
                                            output logic [31:0] d);
    if (a >= 8'd8 || (PROT_EN && p[2])) begin
      d = 32'h0;
      return 2'b10;
    end
    d = model_mem[a[2:0]];
    return 2'b00;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 8; i++) model_mem[i] = 32'h0;
  endfunction

  // ---------------------------------------------------------------- bus drivers
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic send_aw(input logic [7:0] a, input logic [2:0] p);
    int n = 0;
    bus.AWADDR = a; bus.AWPROT = p; bus.AWVALID = 1'b1;
    while (bus.AWREADY !== 1'b1 && n < MAXW) begin tick(); n++; end
    if (n >= MAXW) begin chk_total++; $display("FAIL aw_timeout: AWREADY=%b want 1", bus.AWREADY); end
    tick();
    bus.AWVALID = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    bus.WDATA = d; bus.WSTRB = s; bus.WVALID = 1'b1;
    while (bus.WREADY !== 1'b1 && n < MAXW) begin tick(); n++; end
    if (n >= MAXW) begin chk_total++; $display("FAIL w_timeout: WREADY=%b want 1", bus.WREADY); end
    tick();
    bus.WVALID = 1'b0;
  endtask

  task automatic send_aw_w(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [2:0] p);
    int n = 0;
    bus.AWADDR = a; bus.AWPROT = p; bus.AWVALID = 1'b1;
    bus.WDATA = d; bus.WSTRB = s; bus.WVALID = 1'b1;
    while (!(bus.AWREADY === 1'b1 && bus.WREADY === 1'b1) && n < MAXW) begin tick(); n++; end
    if (n >= MAXW) begin chk_total++; $display("FAIL aww_timeout: AWREADY=%b WREADY=%b want 1", bus.AWREADY, bus.WREADY); end
    tick();
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
  endtask

  task automatic send_ar(input logic [7:0] a, input logic [2:0] p);
    int n = 0;
    bus.ARADDR = a; bus.ARPROT = p; bus.ARVALID = 1'b1;
    while (bus.ARREADY !== 1'b1 && n < MAXW) begin tick(); n++; end
    if (n >= MAXW) begin chk_total++; $display("FAIL ar_timeout: ARREADY=%b want 1", bus.ARREADY); end
    tick();
    bus.ARVALID = 1'b0;
  endtask

  // lat = cycles waited after the final request handshake before BVALID was seen.
  task automatic get_b(output logic [1:0] resp, output int lat);
    lat = 0;
    bus.BREADY = 1'b1;
    while (bus.BVALID !== 1'b1 && lat < MAXW) begin tick(); lat++; end
    if (lat >= MAXW) begin chk_total++; $display("FAIL b_timeout: BVALID=%b want 1", bus.BVALID); end
    resp = bus.BRESP;
    tick();
    bus.BREADY = 1'b0;
  endtask

  task automatic get_r(output logic [31:0] data, output logic [1:0] resp, output int lat);
    lat = 0;
    bus.RREADY = 1'b1;
    while (bus.RVALID !== 1'b1 && lat < MAXW) begin tick(); lat++; end
    if (lat >= MAXW) begin chk_total++; $display("FAIL r_timeout: RVALID=%b want 1", bus.RVALID); end
    data = bus.RDATA;
    resp = bus.RRESP;
    tick();
    bus.RREADY = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [2:0] p, output logic [1:0] resp, output int lat);
    exp_b.push_back(model_write(a, d, s, p));
    send_aw_w(a, d, s, p);
    get_b(resp, lat);
  endtask

  task automatic do_read(input logic [7:0] a, input logic [2:0] p, output logic [31:0] data,
                         output logic [1:0] resp, output int lat);
    logic [31:0] md;
    exp_rr.push_back(model_read(a, p, md));
    exp_rd.push_back(md);
    send_ar(a, p);
    get_r(data, resp, lat);
  endtask

  // ---------------------------------------------------------------- scenarios
  logic [1:0]  resp, eb, er;
  logic [31:0] data, ed;
  int          lat;

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    chk_total++; if ({bus.AWREADY, bus.WREADY, bus.BVALID, bus.BRESP, bus.ARREADY, bus.RVALID, bus.RRESP, bus.RDATA} !== '0)
      $display("FAIL reset_outputs: got %h want 0", {bus.AWREADY, bus.WREADY, bus.BVALID, bus.BRESP, bus.ARREADY, bus.RVALID, bus.RRESP, bus.RDATA}); else chk_pass++;
    reset = 1'b0;
    #1;
    chk_total++; if ({bus.AWREADY, bus.WREADY, bus.ARREADY} !== 3'b000)
      $display("FAIL reset_rst_state: readies %b want 000", {bus.AWREADY, bus.WREADY, bus.ARREADY}); else chk_pass++;
    tick();
    chk_total++; if ({bus.AWREADY, bus.WREADY, bus.ARREADY} !== 3'b111)
      $display("FAIL reset_idle_ready: readies %b want 111", {bus.AWREADY, bus.WREADY, bus.ARREADY}); else chk_pass++;
    model_clear();
  endtask

  task automatic test_basic();
    do_write(8'd1, 32'h0000_0007, 4'hF, 3'b000, resp, lat);
    eb = exp_b.pop_front();
    chk_total++; if (resp !== eb) $display("FAIL basic_bresp: got %b want %b", resp, eb); else chk_pass++;
    chk_total++; if (lat !== 0) $display("FAIL basic_b_latency: got %0d want 0", lat); else chk_pass++;
    do_read(8'd1, 3'b000, data, resp, lat);
    ed = exp_rd.pop_front(); er = exp_rr.pop_front();
    chk_total++; if (data !== ed || data !== 32'h7) $display("FAIL basic_rdata: got %h want %h", data, ed); else chk_pass++;
    chk_total++; if (resp !== er) $display("FAIL basic_rresp: got %b want %b", resp, er); else chk_pass++;
    chk_total++; if (lat !== 0) $display("FAIL basic_r_latency: got %0d want 0", lat); else chk_pass++;
  endtask

  task automatic test_strobe();
    logic [3:0] strbs [3] = '{4'hF, 4'b0101, 4'h0};
    logic [31:0] vals [3] = '{32'hAABB_CCDD, 32'h1122_3344, 32'hFFFF_FFFF};
    for (int k = 0; k < 3; k++) begin
      do_write(8'd2, vals[k], strbs[k], 3'b000, resp, lat);
      eb = exp_b.pop_front();
      chk_total++; if (resp !== eb) $display("FAIL strobe_bresp%0d: got %b want %b", k, resp, eb); else chk_pass++;
    end
    do_read(8'd2, 3'b000, data, resp, lat);
    ed = exp_rd.pop_front(); er = exp_rr.pop_front();
    chk_total++; if (data !== ed || data !== 32'hAA22_CC44) $display("FAIL strobe_rdata: got %h want %h", data, ed); else chk_pass++;
    chk_total++; if (resp !== er) $display("FAIL strobe_rresp: got %b want %b", resp, er); else chk_pass++;
  endtask

  task automatic test_split();
    // Address first.
    exp_b.push_back(model_write(8'd3, 32'h55, 4'hF, 3'b000));
    send_aw(8'd3, 3'b000);
    for (int c = 0; c < 3; c++) begin
      chk_total++; if ({bus.AWREADY, bus.WREADY, bus.BVALID} !== 3'b010)
        $display("FAIL split_a_wait%0d: AW/W/B %b want 010", c, {bus.AWREADY, bus.WREADY, bus.BVALID}); else chk_pass++;
      tick();
    end
    send_w(32'h55, 4'hF);
    get_b(resp, lat);
    eb = exp_b.pop_front();
    chk_total++; if (resp !== eb || lat !== 0) $display("FAIL split_a_b: resp %b lat %0d want %b lat 0", resp, lat, eb); else chk_pass++;
    do_read(8'd3, 3'b000, data, resp, lat);
    ed = exp_rd.pop_front(); er = exp_rr.pop_front();
    chk_total++; if (data !== ed || resp !== er) $display("FAIL split_a_read: got %h/%b want %h/%b", data, resp, ed, er); else chk_pass++;
    // Data first.
    exp_b.push_back(model_write(8'd4, 32'h66, 4'hF, 3'b000));
    send_w(32'h66, 4'hF);
    for (int c = 0; c < 3; c++) begin
      chk_total++; if ({bus.AWREADY, bus.WREADY, bus.BVALID} !== 3'b100)
        $display("FAIL split_d_wait%0d: AW/W/B %b want 100", c, {bus.AWREADY, bus.WREADY, bus.BVALID}); else chk_pass++;
      tick();
    end
    send_aw(8'd4, 3'b000);
    get_b(resp, lat);
    eb = exp_b.pop_front();
    chk_total++; if (resp !== eb || lat !== 0) $display("FAIL split_d_b: resp %b lat %0d want %b lat 0", resp, lat, eb); else chk_pass++;
    do_read(8'd4, 3'b000, data, resp, lat);
    ed = exp_rd.pop_front(); er = exp_rr.pop_front();
    chk_total++; if (data !== ed || resp !== er) $display("FAIL split_d_read: got %h/%b want %h/%b", data, resp, ed, er); else chk_pass++;
  endtask

  task automatic test_out_of_range();
    logic [7:0] addrs [2] = '{8'd8, 8'd255};
    for (int k = 0; k < 2; k++) begin
      do_write(addrs[k], 32'hDEAD_BEEF, 4'hF, 3'b000, resp, lat);
      eb = exp_b.pop_front();
      chk_total++; if (resp !== eb || resp !== 2'b10) $display("FAIL oor_bresp%0d: got %b want %b", k, resp, eb); else chk_pass++;
      do_read(addrs[k], 3'b000, data, resp, lat);
      ed = exp_rd.pop_front(); er = exp_rr.pop_front();
      chk_total++; if (data !== ed || resp !== er) $display("FAIL oor_read%0d: got %h/%b want %h/%b", k, data, resp, ed, er); else chk_pass++;
    end
    for (int a = 0; a < 8; a++) begin
      do_read(8'(a), 3'b000, data, resp, lat);
      ed = exp_rd.pop_front(); er = exp_rr.pop_front();
      chk_total++; if (data !== ed || resp !== er) $display("FAIL oor_mem%0d: got %h/%b want %h/%b", a, data, resp, ed, er); else chk_pass++;
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] md;
    exp_b.push_back(model_write(8'd7, 32'h1234_5678, 4'hF, 3'b000));
    send_aw_w(8'd7, 32'h1234_5678, 4'hF, 3'b000);
    eb = exp_b.pop_front();
    for (int c = 0; c < 5; c++) begin
      chk_total++; if ({bus.BVALID, bus.BRESP, bus.AWREADY, bus.WREADY} !== {1'b1, eb, 2'b00})
        $display("FAIL bp_b_hold%0d: B/resp/AW/W %b want %b", c, {bus.BVALID, bus.BRESP, bus.AWREADY, bus.WREADY}, {1'b1, eb, 2'b00}); else chk_pass++;
      tick();
    end
    bus.BREADY = 1'b1;
    tick();
    bus.BREADY = 1'b0;
    chk_total++; if ({bus.BVALID, bus.AWREADY, bus.WREADY} !== 3'b011)
      $display("FAIL bp_b_release: B/AW/W %b want 011", {bus.BVALID, bus.AWREADY, bus.WREADY}); else chk_pass++;
    er = model_read(8'd7, 3'b000, md);
    send_ar(8'd7, 3'b000);
    for (int c = 0; c < 5; c++) begin
      chk_total++; if ({bus.RVALID, bus.RRESP, bus.RDATA, bus.ARREADY} !== {1'b1, er, md, 1'b0})
        $display("FAIL bp_r_hold%0d: got %h want %h", c, {bus.RVALID, bus.RRESP, bus.RDATA, bus.ARREADY}, {1'b1, er, md, 1'b0}); else chk_pass++;
      tick();
    end
    bus.RREADY = 1'b1;
    tick();
    bus.RREADY = 1'b0;
    chk_total++; if ({bus.RVALID, bus.ARREADY} !== 2'b01)
      $display("FAIL bp_r_release: R/AR %b want 01", {bus.RVALID, bus.ARREADY}); else chk_pass++;
  endtask

  task automatic test_same_edge();
    logic [31:0] md;
    do_write(8'd5, 32'h0BAD_F00D, 4'hF, 3'b000, resp, lat);
    eb = exp_b.pop_front();
    chk_total++; if (resp !== eb) $display("FAIL same_pre_bresp: got %b want %b", resp, eb); else chk_pass++;
    // Read expectation taken before the write is applied to the model.
    exp_rr.push_back(model_read(8'd5, 3'b000, md));
    exp_rd.push_back(md);
    exp_b.push_back(model_write(8'd5, 32'hCAFE_0001, 4'hF, 3'b000));
    bus.AWADDR = 8'd5; bus.AWPROT = 3'b000; bus.AWVALID = 1'b1;
    bus.WDATA = 32'hCAFE_0001; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
    bus.ARADDR = 8'd5; bus.ARPROT = 3'b000; bus.ARVALID = 1'b1;
    tick();
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
    chk_total++; if ({bus.BVALID, bus.RVALID} !== 2'b11)
      $display("FAIL same_valids: B/R %b want 11", {bus.BVALID, bus.RVALID}); else chk_pass++;
    get_b(resp, lat);
    get_r(data, er, lat);
    eb = exp_b.pop_front(); ed = exp_rd.pop_front();
    chk_total++; if (data !== ed || data !== 32'h0BAD_F00D) $display("FAIL same_old_data: got %h want %h", data, ed); else chk_pass++;
    chk_total++; if (resp !== eb) $display("FAIL same_bresp: got %b want %b", resp, eb); else chk_pass++;
    void'(exp_rr.pop_front());
    do_read(8'd5, 3'b000, data, resp, lat);
    ed = exp_rd.pop_front(); er = exp_rr.pop_front();
    chk_total++; if (data !== ed || resp !== er) $display("FAIL same_new_data: got %h/%b want %h/%b", data, resp, ed, er); else chk_pass++;
  endtask

  task automatic test_back_to_back();
    bus.BREADY = 1'b1;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1; bus.AWPROT = 3'b000; bus.WSTRB = 4'hF;
    for (int k = 0; k < 4; k++) begin
      bus.AWADDR = 8'(k);
      bus.WDATA  = 32'hB0B0_0000 + 32'(k);
      exp_b.push_back(model_write(8'(k), 32'hB0B0_0000 + 32'(k), 4'hF, 3'b000));
      tick();
      eb = exp_b.pop_front();
      chk_total++; if ({bus.BVALID, bus.BRESP, bus.AWREADY} !== {1'b1, eb, 1'b0})
        $display("FAIL b2b_resp%0d: B/resp/AW %b want %b", k, {bus.BVALID, bus.BRESP, bus.AWREADY}, {1'b1, eb, 1'b0}); else chk_pass++;
      tick();
      chk_total++; if ({bus.BVALID, bus.AWREADY, bus.WREADY} !== 3'b011)
        $display("FAIL b2b_ready%0d: B/AW/W %b want 011", k, {bus.BVALID, bus.AWREADY, bus.WREADY}); else chk_pass++;
    end
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.BREADY = 1'b0;
    for (int k = 0; k < 4; k++) begin
      do_read(8'(k), 3'b000, data, resp, lat);
      ed = exp_rd.pop_front(); er = exp_rr.pop_front();
      chk_total++; if (data !== ed || resp !== er) $display("FAIL b2b_read%0d: got %h/%b want %h/%b", k, data, resp, ed, er); else chk_pass++;
    end
  endtask

  task automatic test_reset_mid();
    send_aw(8'd6, 3'b000);
    chk_total++; if ({bus.AWREADY, bus.WREADY} !== 2'b01)
      $display("FAIL mid_have_a: AW/W %b want 01", {bus.AWREADY, bus.WREADY}); else chk_pass++;
    reset = 1'b1;
    #1;
    chk_total++; if ({bus.AWREADY, bus.WREADY, bus.BVALID, bus.BRESP, bus.ARREADY, bus.RVALID, bus.RRESP, bus.RDATA} !== '0)
      $display("FAIL mid_outputs: got %h want 0", {bus.AWREADY, bus.WREADY, bus.BVALID, bus.BRESP, bus.ARREADY, bus.RVALID, bus.RRESP, bus.RDATA}); else chk_pass++;
    model_clear();
    tick(); tick();
    reset = 1'b0;
    tick();
    for (int c = 0; c < 3; c++) begin
      chk_total++; if ({bus.BVALID, bus.AWREADY, bus.WREADY} !== 3'b011)
        $display("FAIL mid_no_resp%0d: B/AW/W %b want 011", c, {bus.BVALID, bus.AWREADY, bus.WREADY}); else chk_pass++;
      tick();
    end
    for (int k = 0; k < 8; k++) begin
      do_read(8'(k), 3'b000, data, resp, lat);
      ed = exp_rd.pop_front(); er = exp_rr.pop_front();
      chk_total++; if (data !== ed || data !== 32'h0 || resp !== er) $display("FAIL mid_cleared%0d: got %h/%b want %h/%b", k, data, resp, ed, er); else chk_pass++;
    end
  endtask

  task automatic test_prot();
    logic [1:0] want;
    want = PROT_EN ? 2'b10 : 2'b00;
    do_write(8'd0, 32'hDEAD_0000, 4'hF, 3'b110, resp, lat);
    eb = exp_b.pop_front();
    chk_total++; if (resp !== eb || resp !== want) $display("FAIL prot_bresp: got %b want %b", resp, want); else chk_pass++;
    do_read(8'd0, 3'b100, data, resp, lat);
    ed = exp_rd.pop_front(); er = exp_rr.pop_front();
    chk_total++; if (data !== ed || resp !== er) $display("FAIL prot_read_instr: got %h/%b want %h/%b", data, resp, ed, er); else chk_pass++;
    do_read(8'd0, 3'b000, data, resp, lat);
    ed = exp_rd.pop_front(); er = exp_rr.pop_front();
    chk_total++; if (data !== ed || resp !== er) $display("FAIL prot_read_data: got %h/%b want %h/%b", data, resp, ed, er); else chk_pass++;
  endtask

  initial begin
    bus.AWADDR = '0; bus.AWPROT = '0; bus.AWVALID = 1'b0;
    bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 1'b0; bus.BREADY = 1'b0;
    bus.ARADDR = '0; bus.ARPROT = '0; bus.ARVALID = 1'b0; bus.RREADY = 1'b0;
    reset = 1'b1;
    model_clear();
    test_reset();
    test_basic();
    test_strobe();
    test_split();
    test_out_of_range();
    test_backpressure();
    test_same_edge();
    test_back_to_back();
    test_reset_mid();
    test_prot();
    $display("%0d/%0d checks passed", chk_pass, chk_total);
    $finish;
  end

endmodule
